// File: rtl/bp_cce_fetch_ctrl.sv
// rtl/bp_cce_fetch_ctrl.sv - CCE instruction RAM sequencer owning the fetch PC
module bp_cce_fetch_ctrl #(
    parameter int width_p      = 8,
    parameter int inst_width_p = 48
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cfg_w_v_i,
    input  logic [width_p-1:0]      cfg_addr_i,
    input  logic [inst_width_p-1:0] cfg_data_i,
    output logic                    cfg_ready_o,
    input  logic                    start_i,
    output logic                    ram_v_o,
    output logic                    ram_w_o,
    output logic [width_p-1:0]      ram_addr_o,
    output logic [inst_width_p-1:0] ram_data_o,
    input  logic [inst_width_p-1:0] ram_data_i,
    output logic [width_p-1:0]      pc_o,
    input  logic [width_p-1:0]      predicted_next_pc_i,
    output logic                    inst_v_o,
    output logic [inst_width_p-1:0] inst_o,
    input  logic                    stall_i,
    input  logic                    mispredict_i,
    input  logic [width_p-1:0]      redirect_pc_i
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_INIT  = 2'd1,
        S_FETCH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] pc_q, pc_d;

    // State and PC registers; reset drops any in-flight RAM access with the state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_RESET;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, next-PC and RAM/decode outputs; the RAM address issued each
    // FETCH cycle is always the PC loaded next, so pc_o tracks ram_data_i
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cfg_ready_o = 1'b0;
        ram_v_o     = 1'b0;
        ram_w_o     = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        pc_o        = '0;
        inst_v_o    = 1'b0;
        inst_o      = '0;
        case (state_q)
            S_RESET: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                cfg_ready_o = 1'b1;
                pc_o        = pc_q;
                if (cfg_w_v_i) begin
                    ram_v_o    = 1'b1;
                    ram_w_o    = 1'b1;
                    ram_addr_o = cfg_addr_i;
                    ram_data_o = cfg_data_i;
                end else if (start_i) begin
                    ram_v_o    = 1'b1;
                    ram_addr_o = '0;
                    pc_d       = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                ram_v_o = 1'b1;
                pc_o    = pc_q;
                inst_o  = ram_data_i;
                if (mispredict_i) begin
                    ram_addr_o = redirect_pc_i;
                    pc_d       = redirect_pc_i;
                end else if (stall_i) begin
                    inst_v_o   = 1'b1;
                    ram_addr_o = pc_q;
                end else begin
                    inst_v_o   = 1'b1;
                    ram_addr_o = predicted_next_pc_i;
                    pc_d       = predicted_next_pc_i;
                end
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_bp_cce_fetch_ctrl.sv
// tb/tb_bp_cce_fetch_ctrl.sv - table-driven scoreboard bench for bp_cce_fetch_ctrl
module tb_bp_cce_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_w_v = 1'b0;
    logic [7:0]  cfg_addr = '0;
    logic [47:0] cfg_data = '0;
    logic        cfg_ready;
    logic        start = 1'b0;
    logic        ram_v, ram_w;
    logic [7:0]  ram_addr;
    logic [47:0] ram_wdata;
    logic [47:0] ram_rdata = '0;
    logic [7:0]  pc;
    logic [7:0]  pred_pc;
    logic        inst_v;
    logic [47:0] inst;
    logic        stall = 1'b0;
    logic        mis = 1'b0;
    logic [7:0]  redir = '0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    bp_cce_fetch_ctrl #(.width_p(8), .inst_width_p(48)) dut (
        .clk_i(clk), .reset_i(rst),
        .cfg_w_v_i(cfg_w_v), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data),
        .cfg_ready_o(cfg_ready), .start_i(start),
        .ram_v_o(ram_v), .ram_w_o(ram_w), .ram_addr_o(ram_addr),
        .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
        .pc_o(pc), .predicted_next_pc_i(pred_pc),
        .inst_v_o(inst_v), .inst_o(inst),
        .stall_i(stall), .mispredict_i(mis), .redirect_pc_i(redir)
    );

    // Synchronous-read instruction RAM
    logic [47:0] mem [256];
    always @(posedge clk) begin
        if (ram_v) begin
            if (ram_w) mem[ram_addr] <= ram_wdata;
            else       ram_rdata <= mem[ram_addr];
        end
    end

    // Pre-decoder stand-in: fall-through except a branch at PC 2 to 0x40
    logic [7:0] pred_tbl [256];
    assign pred_pc = pred_tbl[pc];

    function automatic logic [47:0] gold(input logic [7:0] a);
        return {8'hA5, a, ~a, 8'h3C ^ a, a + 8'd17, 8'h5A};
    endfunction

    typedef struct {
        logic       cfg_w;
        logic [7:0] cfg_addr;
        logic [47:0] cfg_data;
        logic       start;
        logic       stall;
        logic       mis;
        logic [7:0] redir;
        logic       e_ready;
        logic       e_ram_v;
        logic       e_ram_w;
        logic [7:0] e_addr;
        logic       e_inst_v;
        logic       e_fetch;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vt[$];
    vec_t exp_q[$];

    function automatic vec_t v_init(input logic w, input logic [7:0] a, input logic st,
                                    input logic e_v, input logic [7:0] e_a);
        vec_t v;
        v = '{cfg_w: w, cfg_addr: a, cfg_data: gold(a), start: st, stall: 1'b0, mis: 1'b0,
              redir: 8'h00, e_ready: 1'b1, e_ram_v: e_v, e_ram_w: w, e_addr: e_a,
              e_inst_v: 1'b0, e_fetch: 1'b0, e_pc: 8'h00};
        return v;
    endfunction

    function automatic vec_t v_fetch(input logic st, input logic m, input logic [7:0] r,
                                     input logic [7:0] e_a, input logic e_iv, input logic [7:0] e_pc,
                                     input logic cw);
        vec_t v;
        v = '{cfg_w: cw, cfg_addr: 8'h11, cfg_data: 48'hDEAD_BEEF_0BAD, start: 1'b0, stall: st,
              mis: m, redir: r, e_ready: 1'b0, e_ram_v: 1'b1, e_ram_w: 1'b0, e_addr: e_a,
              e_inst_v: e_iv, e_fetch: 1'b1, e_pc: e_pc};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_table();
        vec_t v, e;
        for (int i = 0; i < vt.size(); i++) begin
            v = vt[i];
            @(posedge clk);
            #1;
            cfg_w_v = v.cfg_w; cfg_addr = v.cfg_addr; cfg_data = v.cfg_data;
            start = v.start; stall = v.stall; mis = v.mis; redir = v.redir;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d cfg_ready", i), 64'(cfg_ready), 64'(e.e_ready));
            chk($sformatf("v%0d ram_v", i), 64'(ram_v), 64'(e.e_ram_v));
            chk($sformatf("v%0d ram_w", i), 64'(ram_w), 64'(e.e_ram_w));
            chk($sformatf("v%0d inst_v", i), 64'(inst_v), 64'(e.e_inst_v));
            if (e.e_ram_v) chk($sformatf("v%0d ram_addr", i), 64'(ram_addr), 64'(e.e_addr));
            if (e.e_ram_w) chk($sformatf("v%0d ram_wdata", i), 64'(ram_wdata), 64'(e.cfg_data));
            if (e.e_fetch) begin
                chk($sformatf("v%0d pc", i), 64'(pc), 64'(e.e_pc));
                chk($sformatf("v%0d inst", i), 64'(inst), 64'(gold(e.e_pc)));
            end
        end
        vt.delete();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " cfg_ready"}, 64'(cfg_ready), 64'd0);
        chk({nm, " ram_v"}, 64'(ram_v), 64'd0);
        chk({nm, " ram_w"}, 64'(ram_w), 64'd0);
        chk({nm, " ram_addr"}, 64'(ram_addr), 64'd0);
        chk({nm, " ram_wdata"}, 64'(ram_wdata), 64'd0);
        chk({nm, " inst_v"}, 64'(inst_v), 64'd0);
        chk({nm, " pc"}, 64'(pc), 64'd0);
        chk({nm, " inst"}, 64'(inst), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pred_tbl[i] = 8'(i + 1);
        pred_tbl[2] = 8'h40;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post-reset RESET");

        // Boot: write with simultaneous start stays in INIT, then load the rest
        vt.push_back(v_init(1'b1, 8'h00, 1'b1, 1'b1, 8'h00));
        vt.push_back(v_init(1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        for (int a = 1; a < 256; a++) vt.push_back(v_init(1'b1, 8'(a), 1'b0, 1'b1, 8'(a)));
        vt.push_back(v_init(1'b0, 8'h00, 1'b1, 1'b1, 8'h00));
        // Fetch: sequential, predicted branch, mispredict to 0xFF and wrap
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h01, 1, 8'h00, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h02, 1, 8'h01, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h40, 1, 8'h02, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h41, 1, 8'h40, 0));
        vt.push_back(v_fetch(0, 1, 8'hFF, 8'hFF, 0, 8'h41, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h00, 1, 8'hFF, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h01, 1, 8'h00, 0));
        // Stall three cycles at PC 5
        vt.push_back(v_fetch(0, 1, 8'h05, 8'h05, 0, 8'h01, 0));
        vt.push_back(v_fetch(1, 0, 8'h00, 8'h05, 1, 8'h05, 0));
        vt.push_back(v_fetch(1, 0, 8'h00, 8'h05, 1, 8'h05, 0));
        vt.push_back(v_fetch(1, 0, 8'h00, 8'h05, 1, 8'h05, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h06, 1, 8'h05, 0));
        // Mispredict with stall and an ignored config write to 0x11
        vt.push_back(v_fetch(1, 1, 8'h10, 8'h10, 0, 8'h06, 1));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h11, 1, 8'h10, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h12, 1, 8'h11, 0));
        // Back-to-back mispredicts: last one wins
        vt.push_back(v_fetch(0, 1, 8'h20, 8'h20, 0, 8'h12, 0));
        vt.push_back(v_fetch(0, 1, 8'h30, 8'h30, 0, 8'h20, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h31, 1, 8'h30, 0));
        vt.push_back(v_fetch(0, 1, 8'h07, 8'h07, 0, 8'h31, 0));
        vt.push_back(v_fetch(0, 0, 8'h00, 8'h08, 1, 8'h07, 0));
        run_table();

        // Reset mid-fetch at PC 7: outputs drop at once, not at the next edge
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cfg_w_v = 1'b0; start = 1'b0; stall = 1'b0; mis = 1'b0;
        @(negedge clk);
        chk_all_zero("reset release RESET");

        // Back in INIT: write with start performs the write and stays in INIT
        vt.push_back(v_init(1'b1, 8'h03, 1'b1, 1'b1, 8'h03));
        vt.push_back(v_init(1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
        run_table();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
